// File: rtl/illusion_command_pkg.sv
`default_nettype none
// ============================================================================
// Module      : illusion_command_pkg
// Description : Shared definitions for the command path: opcode encoding,
//               command-word field positions and the executor state encoding.
//               Used by the management unit, the executor and the encoders
//               on the driver side.
// Revision    : 1.0 - initial release
// ============================================================================
package illusion_command_pkg;

  // Command word layout: [31:28] opcode, [27:24] register index, [23:0] imm
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 28;
  localparam int INDEX_MSB  = 27;
  localparam int INDEX_LSB  = 24;
  localparam int IMM_MSB    = 23;
  localparam int IMM_LSB    = 0;

  // Opcodes 6..15 are reserved and treated as illegal by the executor
  typedef enum logic [3:0] {
    OP_NOP        = 4'd0,
    OP_SET_REG    = 4'd1,
    OP_SET_REG_HI = 4'd2,
    OP_WAIT       = 4'd3,
    OP_WAIT_IDLE  = 4'd4,
    OP_END        = 4'd5
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_WRITE     = 3'd2,
    ST_WAIT      = 3'd3,
    ST_WAIT_IDLE = 3'd4,
    ST_DONE      = 3'd5
  } exec_state_e;

  // Builds a command word from its fields
  function automatic logic [31:0] makeCommand(input logic [3:0]  opcode,
                                              input logic [3:0]  index,
                                              input logic [23:0] imm);
    logic [31:0] word;
    word = '0;
    word[OPCODE_MSB:OPCODE_LSB] = opcode;
    word[INDEX_MSB:INDEX_LSB]   = index;
    word[IMM_MSB:IMM_LSB]       = imm;
    return word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/command_executor_if.sv
`default_nettype none
// ============================================================================
// Module      : command_executor_if
// Description : Command handshake, status flags and register write port of
//               the command executor.
//   master : drives aCommandValid / aCommand / aExternalBusy, observes the rest
//   slave  : the executor side
// Revision    : 1.0 - initial release
// ============================================================================
interface command_executor_if;
  logic        aCommandValid;
  logic [31:0] aCommand;
  logic        aExternalBusy;
  logic        anOutReady;
  logic        anOutExecutionDone;
  logic        anOutBufferEnd;
  logic        anOutCommandError;
  logic        anOutErrorSticky;
  logic        anOutRegWriteEnable;
  logic [3:0]  anOutRegIndex;
  logic [31:0] anOutRegData;

  modport master (
    output aCommandValid, aCommand, aExternalBusy,
    input  anOutReady, anOutExecutionDone, anOutBufferEnd, anOutCommandError,
           anOutErrorSticky, anOutRegWriteEnable, anOutRegIndex, anOutRegData
  );

  modport slave (
    input  aCommandValid, aCommand, aExternalBusy,
    output anOutReady, anOutExecutionDone, anOutBufferEnd, anOutCommandError,
           anOutErrorSticky, anOutRegWriteEnable, anOutRegIndex, anOutRegData
  );
endinterface
`default_nettype wire

// File: rtl/command_register_shadow.sv
`default_nettype none
// ============================================================================
// Module      : command_register_shadow
// Description : REG_COUNT x 32 shadow copy of the GPU control registers.
//               One synchronous write port, one asynchronous read port.
//   aClock/aReset : clock, asynchronous active-low reset (clears all entries)
//   writeEnable/writeIndex/writeData : write port
//   readIndex/readData : combinational read (0 for out-of-range index)
// Revision    : 1.0 - initial release
// ============================================================================
module command_register_shadow #(
  parameter int REG_COUNT = 16
) (
  input  wire logic        aClock,
  input  wire logic        aReset,
  input  wire logic        writeEnable,
  input  wire logic [3:0]  writeIndex,
  input  wire logic [31:0] writeData,
  input  wire logic [3:0]  readIndex,
  output logic      [31:0] readData
);

  logic [31:0] r_mem [REG_COUNT];

  always_ff @(posedge aClock or negedge aReset) begin
    if (!aReset) begin
      for (int i = 0; i < REG_COUNT; i++) r_mem[i] <= '0;
    end else if (writeEnable) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (writeIndex == 4'(i)) r_mem[i] <= writeData;
      end
    end
  end

  // Decoded read keeps the index width independent of REG_COUNT
  always_comb begin
    readData = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (readIndex == 4'(i)) readData = r_mem[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/command_executor.sv
`default_nettype none
// ============================================================================
// Module      : command_executor
// Description : Accepts one command word per handshake, decodes and executes
//               it (register write, timed wait, wait-for-idle, end, NOP) and
//               signals completion with a one-cycle done pulse.
//   aClock : system clock
//   aReset : asynchronous active-low reset
//   bus    : command handshake, status flags and register write port
// Revision    : 1.0 - initial release
// ============================================================================
module command_executor
  import illusion_command_pkg::*;
#(
  parameter int REG_COUNT  = 16,
  parameter int WAIT_WIDTH = 24
) (
  input  wire logic          aClock,
  input  wire logic          aReset,
  command_executor_if.slave  bus
);

  localparam logic [4:0] c_regCount = 5'(REG_COUNT);

  exec_state_e           r_state;
  exec_state_e           w_nextState;
  logic [31:0]           r_command;
  logic [WAIT_WIDTH-1:0] r_counter;
  logic                  r_endFlag;
  logic                  r_errFlag;
  logic                  r_sticky;
  logic                  w_setEnd;
  logic                  w_setErr;
  logic [31:0]           w_shadowData;
  logic [31:0]           w_regData;

  wire logic [3:0]  w_opcode = r_command[OPCODE_MSB:OPCODE_LSB];
  wire logic [3:0]  w_index  = r_command[INDEX_MSB:INDEX_LSB];
  wire logic [23:0] w_imm    = r_command[IMM_MSB:IMM_LSB];
  wire logic        w_write  = (r_state == ST_WRITE);
  wire logic        w_done   = (r_state == ST_DONE);

  // State register plus the datapath registers tied to state transitions
  always_ff @(posedge aClock or negedge aReset) begin
    if (!aReset) begin
      r_state   <= ST_IDLE;
      r_command <= '0;
      r_counter <= '0;
      r_endFlag <= 1'b0;
      r_errFlag <= 1'b0;
      r_sticky  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (r_state == ST_IDLE && bus.aCommandValid) r_command <= bus.aCommand;
      if (r_state == ST_DECODE) begin
        r_endFlag <= w_setEnd;
        r_errFlag <= w_setErr;
        if (w_setErr) r_sticky <= 1'b1;
        r_counter <= w_imm[WAIT_WIDTH-1:0];
      end else if (r_state == ST_WAIT) begin
        r_counter <= r_counter - WAIT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_setEnd    = 1'b0;
    w_setErr    = 1'b0;
    case (r_state)
      ST_IDLE: if (bus.aCommandValid) w_nextState = ST_DECODE;
      ST_DECODE: begin
        w_nextState = ST_DONE;
        case (w_opcode)
          OP_NOP: ;
          OP_SET_REG, OP_SET_REG_HI: begin
            if ({1'b0, w_index} < c_regCount) w_nextState = ST_WRITE;
            else                               w_setErr    = 1'b1;
          end
          // A zero-length wait completes straight away so the counter never wraps
          OP_WAIT:      if (w_imm != '0) w_nextState = ST_WAIT;
          OP_WAIT_IDLE: w_nextState = ST_WAIT_IDLE;
          OP_END:       w_setEnd    = 1'b1;
          default:      w_setErr    = 1'b1;
        endcase
      end
      ST_WRITE:     w_nextState = ST_DONE;
      ST_WAIT:      if (r_counter == WAIT_WIDTH'(1)) w_nextState = ST_DONE;
      ST_WAIT_IDLE: if (!bus.aExternalBusy) w_nextState = ST_DONE;
      ST_DONE:      w_nextState = ST_IDLE;
      default:      w_nextState = ST_IDLE;
    endcase
  end

  // New full register value; the high-byte form merges with the current shadow
  always_comb begin
    w_regData = {8'h00, w_imm};
    if (w_opcode == OP_SET_REG_HI) begin
      w_regData        = w_shadowData;
      w_regData[31:24] = w_imm[7:0];
    end
  end

  command_register_shadow #(
    .REG_COUNT (REG_COUNT)
  ) u_shadow (
    .aClock      (aClock),
    .aReset      (aReset),
    .writeEnable (w_write),
    .writeIndex  (w_index),
    .writeData   (w_regData),
    .readIndex   (w_index),
    .readData    (w_shadowData)
  );

  assign bus.anOutReady          = (r_state == ST_IDLE);
  assign bus.anOutExecutionDone  = w_done;
  assign bus.anOutBufferEnd      = w_done & r_endFlag;
  assign bus.anOutCommandError   = w_done & r_errFlag;
  assign bus.anOutErrorSticky    = r_sticky;
  assign bus.anOutRegWriteEnable = w_write;
  assign bus.anOutRegIndex       = w_write ? w_index : 4'h0;
  assign bus.anOutRegData        = w_write ? w_regData : 32'h0;

endmodule
`default_nettype wire

// File: doc/command_executor.md
Name: command_executor

Overview:
- Downstream stage of the command-buffer management unit.
- Accepts one 32-bit command word per handshake and decodes it.
- Executes the command: register write, timed wait, wait-for-idle, end-of-buffer, or NOP.
- Returns a one-cycle done pulse, which is the management unit's executionDone.
- Holds a shadow copy of the GPU control registers and drives a single write port into the downstream register bank.

Parameters:
- REG_COUNT, 16, number of control registers (1..16); an index >= REG_COUNT is illegal.
- WAIT_WIDTH, 24, width of the WAIT cycle counter; equals the immediate field width.

Ports:
- aClock  input  1  system clock; all state changes on its rising edge.
- aReset  input  1  asynchronous, active-low reset (0 = reset).
- aCommandValid  input  1  command word present; sampled only in Idle.
- aCommand  input  32  command word: [31:28] opcode, [27:24] register index, [23:0] immediate.
- aExternalBusy  input  1  raster/shader busy; consumed by WAIT_IDLE.
- anOutReady  output  1  high exactly while in Idle.
- anOutExecutionDone  output  1  one-cycle pulse when the current command completes.
- anOutBufferEnd  output  1  high together with done for END.
- anOutCommandError  output  1  high together with done for an illegal command.
- anOutErrorSticky  output  1  set on any illegal command; cleared only by reset.
- anOutRegWriteEnable  output  1  one-cycle write strobe.
- anOutRegIndex  output  4  write index; valid with the strobe.
- anOutRegData  output  32  write data; valid with the strobe.

Behaviour:
Reset (aReset=0, asynchronous):
- State=Idle, all shadow registers=0, wait counter=0, sticky=0, latched command=0.
- Every output is 0 except anOutReady=1.
- Reset mid-command aborts it: no done pulse and no write strobe.

Opcodes (shared package):
- 0 NOP.
- 1 SET_REG: reg[idx] <= {8'h0, imm}.
- 2 SET_REG_HI: reg[idx][31:24] <= imm[7:0], low 24 bits kept.
- 3 WAIT imm cycles.
- 4 WAIT_IDLE.
- 5 END.
- 6..15 illegal.

States:
- Idle: aCommandValid=1 -> latch aCommand, go to Decode. aCommandValid while not Idle is ignored; the word is not latched.
- Decode: NOP -> Done.
- Decode: SET_REG or SET_REG_HI with idx < REG_COUNT -> Write; idx >= REG_COUNT -> Done with error.
- Decode: WAIT with imm==0 -> Done; otherwise counter <= imm, go to Wait.
- Decode: WAIT_IDLE -> WaitIdle.
- Decode: END -> Done with end flag.
- Decode: illegal opcode -> Done with error.
- Write: strobe=1 and index=idx. Data is the new full 32-bit value; for SET_REG_HI it is {imm[7:0], shadow[idx][23:0]}. Shadow updated on the same edge. -> Done.
- Wait: counter decrements each cycle; at counter==1 -> Done. Exactly imm cycles are spent in Wait. Arithmetic is unsigned WAIT_WIDTH, with no wrap because the zero case is caught in Decode.
- WaitIdle: aExternalBusy=0 -> Done, otherwise stay. If busy is already low on entry, the state is left after one cycle.
- Done: anOutExecutionDone=1. anOutBufferEnd / anOutCommandError asserted per latched flags for this cycle only. -> Idle.

Latency (valid accepted in cycle T):
- NOP/END/illegal: done in T+2.
- SET_REG/SET_REG_HI: strobe in T+2, done in T+3.
- WAIT n (n>=1): done in T+n+2.
- WAIT_IDLE: done 1 cycle after the first cycle in WaitIdle that samples busy low.

Other rules:
- Back-to-back: the next command can be accepted in the cycle after done, since Idle is re-entered then.
- Outputs are registered or decoded from state only; there are no combinational input-to-output paths.

Decomposition:
- Package illusion_command_pkg holds:
  - the opcode enum (4-bit);
  - field position constants (OPCODE_MSB/LSB, INDEX_MSB/LSB, IMM_MSB/LSB);
  - the executor state enum.
- It is shared with the management unit and the driver-side encoders.
- One natural sub-module: command_register_shadow. It is the REG_COUNT x 32 array with a write port and an asynchronous read at the latched index. The FSM, counter and flags stay in command_executor.

Test Plan:
- Reset: hold aReset=0 mid-WAIT, then release -> Idle, anOutReady=1, no done pulse, reg[3] reads 0.
- Write: SET_REG idx=3 imm=0xABCDEF, then SET_REG_HI idx=3 imm=0x12. First strobe data is 0x00ABCDEF; second strobe data is 0x12ABCDEF, index=3. Each done arrives 1 cycle after its strobe.
- WAIT: WAIT 5 accepted at T -> done exactly at T+7; WAIT 0 accepted at T -> done at T+2.
- WAIT_IDLE: hold aExternalBusy=1 for 10 cycles -> no done. Drop busy -> done 2 cycles later. aCommandValid pulses during the wait are ignored.
- Flags: illegal opcode 0x9 -> done with anOutCommandError=1, anOutErrorSticky stays 1. SET_REG idx=12 with REG_COUNT=8 -> error, no strobe. END -> done with anOutBufferEnd=1.
- Throughput: 4 NOPs presented as soon as anOutReady returns -> done pulses every 3 cycles, none lost.
